ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, giving the clock-low inhibit time in clock cycles (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 750000, giving the maximum wait for any device clock edge (15 ms at 50 MHz).
REQ-003 The block SHALL have port clock, input, 1 bit: single system clock (CLOCK_50); the only clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: command byte to send to the keyboard.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: request to send tx_data.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: high only in IDLE.
REQ-008 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse on successful frame.
REQ-009 The block SHALL have port tx_error, output, 1 bit: one-cycle pulse on a failed frame.
REQ-010 The block SHALL have ports ps2_clk_in and ps2_dat_in, input, 1 bit each: raw PS2_KBCLK and PS2_KBDAT pin levels.
REQ-011 The block SHALL have ports ps2_clk_oe and ps2_dat_oe, output, 1 bit each: 1 drives the pin low, 0 releases it (open-drain).

Function
REQ-012 The block SHALL pass ps2_clk_in and ps2_dat_in through 2-FF synchronizers and SHALL produce a one-cycle fall pulse when synced clock goes 1->0.
REQ-013 The FSM SHALL have these states: IDLE, INHIBIT, START, SHIFT, ACK, RELEASE.
REQ-014 In IDLE, on tx_valid && tx_ready, the block SHALL latch the frame {stop=1, parity=~^tx_data, tx_data}, assert ps2_clk_oe and enter INHIBIT.
REQ-015 In INHIBIT, the block SHALL hold ps2_clk_oe for exactly INHIBIT_CYCLES cycles, then assert ps2_dat_oe (start bit 0) and enter START.
REQ-016 START SHALL last one cycle with both oe asserted, then deassert ps2_clk_oe and enter SHIFT with the bit counter at 0.
REQ-017 In SHIFT, on each fall pulse the block SHALL set ps2_dat_oe = ~frame[count] and increment count, driving bits LSB first in this order: data0..data7, parity, stop (released).
REQ-018 After the 10th fall pulse, the block SHALL enter ACK.
REQ-019 On the 11th fall pulse in ACK, the block SHALL sample synced data: 0 means success, 1 means error (see REQ-026).
REQ-020 In RELEASE, the block SHALL wait until synced clock and data are both 1, then pulse tx_done or tx_error and return to IDLE.
REQ-021 A timeout counter SHALL reset on every fall pulse and on every state entry; if it reaches TIMEOUT_CYCLES in START, SHIFT, ACK or RELEASE, the block SHALL release both oe, pulse tx_error and go to IDLE.
REQ-022 tx_valid SHALL be ignored outside IDLE, and tx_data SHALL be ignored after acceptance.
REQ-023 tx_done and tx_error SHALL never be asserted together.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, and all counters and synchronizers to 1/idle levels; tx_ready SHALL read 1 after reset.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without producing a tx_done or tx_error pulse.

Configuration
REQ-026 With PS2_TX_ACK_CHECK_EN defined, an ACK sample of 1 SHALL produce tx_error; without it, the ACK level SHALL be ignored and the 11th fall pulse SHALL always lead to tx_done (the timeout still applies).

Structure
REQ-027 A shared package SHALL hold the state enum, the PS2 frame length (11) and the keyboard command constants (0xED set-LEDs, 0xFF reset, 0xF4 enable).
REQ-028 Sub-module ps2_sync SHALL contain the 2-FF synchronizer and falling-edge detector, with one instance per line.

Verification
REQ-029 Send 0xED with INHIBIT_CYCLES=50 and a device model clocking at 12.5 kHz -> ps2_clk_oe held low for 50 cycles; observed data bits 1,0,1,1,0,1,1,1 then parity 1, stop 1; ACK 0 -> one tx_done.
REQ-030 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; both frames end with tx_done.
REQ-031 With TIMEOUT_CYCLES=1000 and a device that never clocks -> both oe released and tx_error pulses 1000 cycles after START is entered.
REQ-032 With PS2_TX_ACK_CHECK_EN defined and ACK=1 -> tx_error; the same stimulus built without the macro -> tx_done.
REQ-033 Assert reset after the 4th fall pulse -> both oe are 0 in the same cycle, no done/error pulse, tx_ready=1; a following send of 0xF4 completes normally.
REQ-034 Hold tx_valid high continuously -> exactly one frame starts per return to IDLE, and tx_ready is 0 throughout each frame.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter:
//   - ps2_tx_state_t : FSM state encoding
//   - PS2_FRAME_LEN  : bits on the wire per frame (start, 8 data, parity, stop)
//   - PS2_TX_BITS    : bits latched for shifting (data, parity, stop; start is
//                      driven separately while the host still holds the clock)
//   - KBD_CMD_*      : common keyboard command bytes
//   - odd_parity()   : PS/2 parity bit for a data byte
// Optional feature macro used by ps2_host_tx: PS2_TX_ACK_CHECK_EN.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_RELEASE
    } ps2_tx_state_t;

    localparam int unsigned PS2_FRAME_LEN = 11;
    localparam int unsigned PS2_TX_BITS   = PS2_FRAME_LEN - 1;

    localparam logic [7:0] KBD_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] KBD_CMD_RESET    = 8'hFF;
    localparam logic [7:0] KBD_CMD_ENABLE   = 8'hF4;

    // Parity bit that makes data + parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// ps2_sync
//   Two-flop synchronizer for one raw PS/2 pin plus a falling-edge detector
//   on the synchronized level. All flops reset to 1 (idle bus level), so no
//   spurious edge is reported out of reset.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high
//   din   - raw pin level
//   sync  - synchronized pin level
//   fall  - one-cycle pulse when sync goes 1 -> 0
module ps2_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter: inhibits the bus, issues a start bit,
//   shifts a command byte out LSB first on the device's falling clock edges,
//   then waits for the acknowledge bit and for the bus to return to idle.
// Parameters:
//   INHIBIT_CYCLES - clock-low inhibit time in system clock cycles
//   TIMEOUT_CYCLES - longest wait for any device clock edge before giving up
// Ports:
//   clock, reset           - system clock; asynchronous active-high reset
//   tx_data, tx_valid      - command byte and send request (taken in IDLE)
//   tx_ready               - high only while IDLE
//   tx_done, tx_error      - one-cycle completion / failure pulses
//   ps2_clk_in, ps2_dat_in - raw PS2_KBCLK / PS2_KBDAT pin levels
//   ps2_clk_oe, ps2_dat_oe - 1 pulls the pin low, 0 releases it
// Configuration:
//   PS2_TX_ACK_CHECK_EN - when defined, an acknowledge bit of 1 ends the frame
//                         with tx_error; otherwise the ACK level is ignored.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'(PS2_TX_BITS - 1);

    ps2_tx_state_t state, state_next;

    logic [PS2_TX_BITS-1:0] frame, frame_next;
    logic [3:0]             bit_cnt, bit_cnt_next;
    logic                   dat_drive, dat_drive_next;
    logic [INH_W-1:0]       inh_cnt, inh_cnt_next;
    logic [TO_W-1:0]        to_cnt, to_cnt_next;
    logic                   done_next, error_next;
    logic                   timed;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;

`ifdef PS2_TX_ACK_CHECK_EN
    logic ack_bad, ack_bad_next;
`endif

    ps2_sync u_clk_sync (
        .clock (clock),
        .reset (reset),
        .din   (ps2_clk_in),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    ps2_sync u_dat_sync (
        .clock (clock),
        .reset (reset),
        .din   (ps2_dat_in),
        .sync  (dat_sync),
        .fall  (dat_fall_unused)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame     <= '1;
            bit_cnt   <= '0;
            dat_drive <= 1'b0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            tx_done   <= 1'b0;
            tx_error  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_bad   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            frame     <= frame_next;
            bit_cnt   <= bit_cnt_next;
            dat_drive <= dat_drive_next;
            inh_cnt   <= inh_cnt_next;
            to_cnt    <= to_cnt_next;
            tx_done   <= done_next;
            tx_error  <= error_next;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_bad   <= ack_bad_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        frame_next     = frame;
        bit_cnt_next   = bit_cnt;
        dat_drive_next = dat_drive;
        inh_cnt_next   = inh_cnt;
        to_cnt_next    = to_cnt;
        done_next      = 1'b0;
        error_next     = 1'b0;
        tx_ready       = 1'b0;
        ps2_clk_oe     = 1'b0;
        ps2_dat_oe     = 1'b0;
        timed          = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_bad_next   = ack_bad;
`endif

        unique case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    frame_next   = {1'b1, odd_parity(tx_data), tx_data};
                    inh_cnt_next = '0;
                    state_next   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == INH_LAST) begin
                    state_next = ST_START;
                end else begin
                    inh_cnt_next = inh_cnt + 1'b1;
                end
            end

            ST_START: begin
                timed          = 1'b1;
                ps2_clk_oe     = 1'b1;
                ps2_dat_oe     = 1'b1;
                bit_cnt_next   = '0;
                dat_drive_next = 1'b1;
                state_next     = ST_SHIFT;
            end

            ST_SHIFT: begin
                // The start bit stays driven until the device's first falling
                // edge; each later edge advances to the next latched bit.
                timed      = 1'b1;
                ps2_dat_oe = dat_drive;
                if (clk_fall) begin
                    dat_drive_next = ~frame[bit_cnt];
                    bit_cnt_next   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                timed = 1'b1;
                if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_bad_next = dat_sync;
`endif
                    state_next = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                timed = 1'b1;
                if (clk_sync && dat_sync) begin
                    state_next = ST_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                    done_next  = ~ack_bad;
                    error_next = ack_bad;
`else
                    done_next  = 1'b1;
`endif
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A device edge restarts the timeout wait, so it wins over expiry.
        if (timed && !clk_fall && to_cnt == TO_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
            error_next = 1'b1;
        end

        if (clk_fall) begin
            to_cnt_next = '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt_next = to_cnt + 1'b1;
        end

        // START -> SHIFT is one continuous wait for the device's first clock
        // edge, so the timeout keeps counting from START entry across it.
        if (state_next != state && !(state == ST_START && state_next == ST_SHIFT)) begin
            to_cnt_next = '0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with a behavioural PS/2 device on an
//   open-drain bus model. Device half-period is scaled to HALF system clocks.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int unsigned INH  = 50;
    localparam int unsigned TOUT = 1000;
    localparam int          HALF = 40;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK1_DONE = 1'b0;
`else
    localparam bit ACK1_DONE = 1'b1;
`endif

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] exp_bits;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low, dev_dat_low;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0, err_cnt = 0, frames_started = 0, ready_cycles = 0;
    bit count_ready = 1'b0;
    logic prev_clk_oe = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #10 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always @(posedge clock) begin
        #1;
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) begin
            n_miss++;
            $display("FAIL done_and_error: both pulses high at %0t, required never together", $time);
        end
        if (ps2_clk_oe && !prev_clk_oe) frames_started++;
        prev_clk_oe = ps2_clk_oe;
        if (count_ready && tx_ready) ready_cycles++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Counts INHIBIT cycles (clk_oe alone); returns on the first START cycle.
    task automatic measure_inhibit(output int n);
        int w = 0;
        n = 0;
        while (!ps2_clk_oe && w < 100) begin
            w++;
            @(negedge clock);
        end
        while (ps2_clk_oe && !ps2_dat_oe && n < 1000) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Device generates n clock pulses, sampling data before each rising edge;
    // after the 10th pulse it drives the ACK level, then releases data.
    task automatic device_clock(input int n, input bit ack, output logic [9:0] bits);
        bits = '0;
        for (int i = 1; i <= n; i++) begin
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            if (i <= 10) bits[i-1] = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (i == 10 && !ack) dev_dat_low = 1'b1;
        end
        if (n == 11) begin
            repeat (HALF) @(negedge clock);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic run_vector(input string tag, input vec_t v);
        int d0, e0, inh;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        tx_data  = ~v.data;
        check({tag, "_ready_low"}, {31'b0, tx_ready}, 32'd0);
        measure_inhibit(inh);
        check({tag, "_inhibit_cycles"}, inh, INH);
        check({tag, "_start_both_oe"}, {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
        device_clock(11, v.ack, bits);
        check({tag, "_bits"}, {22'b0, bits}, {22'b0, v.exp_bits});
        repeat (20) @(negedge clock);
        check({tag, "_done"}, done_cnt - d0, {31'b0, v.exp_done});
        check({tag, "_error"}, err_cnt - e0, {31'b0, v.exp_err});
        check({tag, "_ready_after"}, {31'b0, tx_ready}, 32'd1);
    endtask

    initial begin
        vec_t vecs[4];
        logic [9:0] bits;
        int inh, d0, e0, fs0;

        vecs[0] = '{KBD_CMD_SET_LEDS, 1'b0, 10'h3ED, 1'b1, 1'b0};
        vecs[1] = '{8'h00,            1'b0, 10'h300, 1'b1, 1'b0};
        vecs[2] = '{8'h01,            1'b0, 10'h201, 1'b1, 1'b0};
        vecs[3] = '{KBD_CMD_RESET,    1'b1, 10'h3FF, ACK1_DONE, !ACK1_DONE};

        reset = 1'b1;
        tx_data = '0;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {27'b0, tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'h10);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            run_vector($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset after the 4th device falling edge while the host drives a 0.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        measure_inhibit(inh);
        device_clock(3, 1'b0, bits);
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_pre_dat_oe", {31'b0, ps2_dat_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_oe_released", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check("abort_ready", {31'b0, tx_ready}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (3 * HALF) @(negedge clock);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_no_error", err_cnt - e0, 32'd0);
        run_vector("after_abort", '{KBD_CMD_ENABLE, 1'b0, 10'h2F4, 1'b1, 1'b0});

        // Device never clocks: error exactly TOUT cycles after START entry.
        e0 = err_cnt;
        @(negedge clock);
        tx_data  = KBD_CMD_RESET;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        measure_inhibit(inh);
        check("to_start_seen", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
        repeat (TOUT - 1) @(negedge clock);
        check("to_not_early", {30'b0, tx_error, ps2_dat_oe}, 32'd1);
        @(negedge clock);
        check("to_error_pulse", {29'b0, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd4);
        @(negedge clock);
        check("to_error_one_cycle", {30'b0, tx_error, tx_done}, 32'd0);
        check("to_error_count", err_cnt - e0, 32'd1);

        // tx_valid held high: back-to-back frames with one IDLE cycle between.
        d0  = done_cnt;
        fs0 = frames_started;
        @(negedge clock);
        tx_data  = KBD_CMD_ENABLE;
        tx_valid = 1'b1;
        @(negedge clock);
        ready_cycles = 0;
        count_ready  = 1'b1;
        measure_inhibit(inh);
        device_clock(11, 1'b0, bits);
        check("hold_f1_bits", {22'b0, bits}, 32'h2F4);
        measure_inhibit(inh);
        check("hold_f2_inhibit", inh, INH);
        tx_valid = 1'b0;
        device_clock(11, 1'b0, bits);
        count_ready = 1'b0;
        repeat (100) @(negedge clock);
        check("hold_frames_started", frames_started - fs0, 32'd2);
        check("hold_ready_cycles", ready_cycles, 32'd1);
        check("hold_done_count", done_cnt - d0, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
